// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Runs one SUMP capture over the capture BRAM: divides the sample clock, writes samples into a
//   ring buffer, pre-fills, qualifies the trigger, counts post-trigger samples, then streams the
//   captured bytes newest first toward the UART TX path.
//
// Ports
//   CAP_CLK, RST           clock, synchronous active-high reset
//   CAP                    8 input channels
//   cfg_div                sample every cfg_div+1 clocks
//   cfg_mask / cfg_value   trigger mask and required levels
//   cfg_read_cnt           samples to return (clamped to the buffer depth)
//   cfg_delay_cnt          samples to capture after the trigger (clamped to read count)
//   arm / abort            start / cancel pulses from the command decoder
//   BRAM_IN, BRAM_ADDR_W, B_CE_W   BRAM write port
//   BRAM_ADDR_R, B_CE_R, BRAM_OUT  BRAM read port (data one cycle after B_CE_R)
//   out_data/out_valid/out_ready   readback byte stream
//   busy, triggered, done          status
module capture_sequencer #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DIV_W  = 24,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CAP_CLK,
  input  logic              RST,
  input  logic [7:0]        CAP,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [7:0]        cfg_mask,
  input  logic [7:0]        cfg_value,
  input  logic [CNT_W-1:0]  cfg_read_cnt,
  input  logic [CNT_W-1:0]  cfg_delay_cnt,
  input  logic              arm,
  input  logic              abort,
  output logic [7:0]        BRAM_IN,
  output logic [ADDR_W-1:0] BRAM_ADDR_W,
  output logic              B_CE_W,
  output logic [ADDR_W-1:0] BRAM_ADDR_R,
  output logic              B_CE_R,
  input  logic [7:0]        BRAM_OUT,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              triggered,
  output logic              done
);
  // Counts are one bit wider than either the count inputs or the address so the full depth fits.
  localparam int unsigned CW = (CNT_W > ADDR_W) ? CNT_W + 1 : ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1) << ADDR_W;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StWaitTrig,
    StPost,
    StRead,
    StDone
  } state_e;

  state_e r_state, w_state_d, w_read_entry;

  logic [DIV_W-1:0]  r_div, r_div_cnt;
  logic [7:0]        r_mask, r_value;
  logic [CW-1:0]     r_read, r_delay, r_pre;
  logic [CW-1:0]     r_pre_cnt, r_post_cnt, r_issue_left, r_xfer_left;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
  logic              r_pending, r_out_valid, r_triggered;
  logic [7:0]        r_out_data;

  logic [CW-1:0] w_read_ext, w_delay_ext, w_cfg_read, w_cfg_delay, w_cfg_pre, w_pre_cnt_inc;
  logic          w_capturing, w_tick, w_we, w_re, w_hit, w_xfer, w_cap_end;

  assign w_read_ext  = CW'(cfg_read_cnt);
  assign w_delay_ext = CW'(cfg_delay_cnt);
  assign w_cfg_read  = (w_read_ext > DEPTH) ? DEPTH : w_read_ext;
  assign w_cfg_delay = (w_delay_ext > w_cfg_read) ? w_cfg_read : w_delay_ext;
  assign w_cfg_pre   = w_cfg_read - w_cfg_delay;

  assign w_capturing   = (r_state == StPre) || (r_state == StWaitTrig) || (r_state == StPost);
  assign w_tick        = w_capturing && (r_div_cnt == '0);
  // Abort suppresses the enables in its own cycle so the BRAM is left untouched.
  assign w_we          = w_tick && !abort;
  assign w_hit         = ((CAP ^ r_value) & r_mask) == 8'h00;
  assign w_pre_cnt_inc = (r_pre_cnt == DEPTH) ? DEPTH : r_pre_cnt + CW'(1);
  assign w_xfer        = r_out_valid && out_ready;
  // One read in flight at most; the next may issue in the cycle the held byte transfers.
  assign w_re          = (r_state == StRead) && (r_issue_left != '0) && !r_pending &&
                         (!r_out_valid || out_ready) && !abort;
  // Final capture write: trigger sample with no delay, or the last post-trigger sample.
  assign w_cap_end     = w_we && (((r_state == StWaitTrig) && w_hit && (r_delay == '0)) ||
                                  ((r_state == StPost) && (r_post_cnt == CW'(1))));
  assign w_read_entry  = (r_read == '0) ? StDone : StRead;

  always_ff @(posedge CAP_CLK) begin
    if (RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:     if (arm) w_state_d = (w_cfg_pre == '0) ? StWaitTrig : StPre;
      StPre:      if (w_we && (w_pre_cnt_inc == r_pre)) w_state_d = StWaitTrig;
      StWaitTrig: if (w_we && w_hit) w_state_d = (r_delay == '0) ? w_read_entry : StPost;
      StPost:     if (w_cap_end) w_state_d = w_read_entry;
      StRead:     if (w_xfer && (r_xfer_left == CW'(1))) w_state_d = StDone;
      StDone:     w_state_d = StIdle;
      default:    w_state_d = StIdle;
    endcase
    if (abort) w_state_d = StIdle;

    BRAM_IN     = w_we ? CAP : 8'h00;
    BRAM_ADDR_W = w_we ? r_wr_addr : '0;
    B_CE_W      = w_we;
    BRAM_ADDR_R = w_re ? r_rd_addr : '0;
    B_CE_R      = w_re;
    out_data    = r_out_data;
    out_valid   = r_out_valid;
    busy        = (r_state != StIdle);
    triggered   = r_triggered;
    done        = (r_state == StDone);
  end

  always_ff @(posedge CAP_CLK) begin
    if (RST) begin
      r_div        <= '0;
      r_div_cnt    <= '0;
      r_mask       <= '0;
      r_value      <= '0;
      r_read       <= '0;
      r_delay      <= '0;
      r_pre        <= '0;
      r_pre_cnt    <= '0;
      r_post_cnt   <= '0;
      r_issue_left <= '0;
      r_xfer_left  <= '0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_pending    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_triggered  <= 1'b0;
    end else if (abort) begin
      r_div_cnt   <= '0;
      r_pending   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_pending <= w_re;

      if ((r_state == StIdle) && arm) begin
        r_div        <= cfg_div;
        r_mask       <= cfg_mask;
        r_value      <= cfg_value;
        r_read       <= w_cfg_read;
        r_delay      <= w_cfg_delay;
        r_pre        <= w_cfg_pre;
        r_pre_cnt    <= '0;
        r_post_cnt   <= '0;
        r_issue_left <= w_cfg_read;
        r_xfer_left  <= w_cfg_read;
        r_div_cnt    <= '0;
        r_wr_addr    <= '0;
        r_rd_addr    <= '0;
        r_triggered  <= 1'b0;
      end

      if (w_capturing) begin
        r_div_cnt <= (r_div_cnt == r_div) ? '0 : r_div_cnt + DIV_W'(1);
      end

      if (w_we) begin
        r_wr_addr <= r_wr_addr + ADDR_W'(1);
        if (r_state == StPre) r_pre_cnt <= w_pre_cnt_inc;
        if ((r_state == StWaitTrig) && w_hit) begin
          r_triggered <= 1'b1;
          r_post_cnt  <= r_delay;
        end
        if (r_state == StPost) r_post_cnt <= r_post_cnt - CW'(1);
      end

      // Readback starts at the address just written and walks backwards.
      if (w_cap_end) r_rd_addr <= r_wr_addr;

      if (w_re) begin
        r_rd_addr    <= r_rd_addr - ADDR_W'(1);
        r_issue_left <= r_issue_left - CW'(1);
      end

      if (r_pending) begin
        r_out_data  <= BRAM_OUT;
        r_out_valid <= 1'b1;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end

      if (w_xfer) r_xfer_left <= r_xfer_left - CW'(1);
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed testbench for capture_sequencer with a behavioural 8192x8 BRAM.
module tb_capture_sequencer;
  logic        CAP_CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  CAP = 8'h00;
  logic [23:0] cfg_div = '0;
  logic [7:0]  cfg_mask = '0;
  logic [7:0]  cfg_value = '0;
  logic [15:0] cfg_read_cnt = '0;
  logic [15:0] cfg_delay_cnt = '0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  BRAM_IN;
  logic [12:0] BRAM_ADDR_W;
  logic        B_CE_W;
  logic [12:0] BRAM_ADDR_R;
  logic        B_CE_R;
  logic [7:0]  BRAM_OUT = 8'h00;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        triggered;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:8191];

  capture_sequencer dut (
    .CAP_CLK       (CAP_CLK),
    .RST           (RST),
    .CAP           (CAP),
    .cfg_div       (cfg_div),
    .cfg_mask      (cfg_mask),
    .cfg_value     (cfg_value),
    .cfg_read_cnt  (cfg_read_cnt),
    .cfg_delay_cnt (cfg_delay_cnt),
    .arm           (arm),
    .abort         (abort),
    .BRAM_IN       (BRAM_IN),
    .BRAM_ADDR_W   (BRAM_ADDR_W),
    .B_CE_W        (B_CE_W),
    .BRAM_ADDR_R   (BRAM_ADDR_R),
    .B_CE_R        (B_CE_R),
    .BRAM_OUT      (BRAM_OUT),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .triggered     (triggered),
    .done          (done)
  );

  always #5 CAP_CLK = ~CAP_CLK;

  always @(posedge CAP_CLK) begin
    if (B_CE_W) mem[BRAM_ADDR_W] <= BRAM_IN;
    if (B_CE_R) BRAM_OUT <= mem[BRAM_ADDR_R];
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CAP_CLK);
    #1;
  endtask

  task automatic arm_cfg(input logic [23:0] div, input logic [7:0] mask, input logic [7:0] value,
                         input logic [15:0] rd, input logic [15:0] dly);
    cfg_div       = div;
    cfg_mask      = mask;
    cfg_value     = value;
    cfg_read_cnt  = rd;
    cfg_delay_cnt = dly;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Channel pattern for the wrap test: CH0 goes high from sample 100.
  function automatic logic [7:0] f3(input int n);
    logic [7:0] v;
    v = 8'(n);
    return {v[6:0], 1'(n >= 100)};
  endfunction

  task automatic test_reset();
    logic [47:0] all_o;
    RST = 1'b1;
    repeat (3) tick();
    #1;
    all_o = {BRAM_IN, BRAM_ADDR_W, B_CE_W, BRAM_ADDR_R, B_CE_R, out_data, out_valid, busy,
             triggered, done};
    checks++;
    if (all_o !== 48'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", all_o);
    end
    RST = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int got, cyc, last;
    arm_cfg(24'd0, 8'h00, 8'h00, 16'd16, 16'd8);
    for (int n = 0; n <= 16; n++) begin
      CAP = 8'(n);
      #1;
      checks++;
      if (B_CE_W !== 1'b1 || BRAM_ADDR_W !== 13'(n) || BRAM_IN !== 8'(n)) begin
        errors++;
        $display("FAIL basic_write n=%0d: ce=%b addr=%0d data=%h want 1 %0d %h", n, B_CE_W,
                 BRAM_ADDR_W, BRAM_IN, n, 8'(n));
      end
      checks++;
      if (triggered !== 1'(n > 8) || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_trig n=%0d: trig=%b busy=%b want %b 1", n, triggered, busy,
                 1'(n > 8));
      end
      tick();
    end
    out_ready = 1'b1;
    got = 0;
    cyc = 0;
    last = -1;
    while (got < 16 && cyc < 100) begin
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== 8'(16 - got)) begin
          errors++;
          $display("FAIL basic_byte %0d: got %h want %h", got, out_data, 8'(16 - got));
        end
        got++;
        if (got == 16) last = cyc;
      end
      checks++;
      if (B_CE_W !== 1'b0) begin
        errors++;
        $display("FAIL basic_no_write_in_read: ce_w=%b want 0", B_CE_W);
      end
      if (got < 16) begin
        tick();
        cyc++;
      end
    end
    checks++;
    if (got != 16 || last != 32) begin
      errors++;
      $display("FAIL basic_count: bytes=%0d last_cycle=%0d want 16 32", got, last);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b want 1 1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || triggered !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: done=%b busy=%b trig=%b want 0 0 1", done, busy, triggered);
    end
  endtask

  task automatic test_divider();
    arm_cfg(24'd3, 8'h00, 8'h00, 16'd16, 16'd8);
    for (int k = 0; k <= 64; k++) begin
      CAP = 8'(k);
      #1;
      checks++;
      if (B_CE_W !== 1'(k % 4 == 0)) begin
        errors++;
        $display("FAIL div_ce k=%0d: ce=%b want %b", k, B_CE_W, 1'(k % 4 == 0));
      end
      if (k % 4 == 0) begin
        checks++;
        if (BRAM_ADDR_W !== 13'(k / 4)) begin
          errors++;
          $display("FAIL div_addr k=%0d: addr=%0d want %0d", k, BRAM_ADDR_W, k / 4);
        end
      end
      tick();
    end
    #1;
    checks++;
    if (B_CE_W !== 1'b0 || B_CE_R !== 1'b1 || BRAM_ADDR_R !== 13'd16) begin
      errors++;
      $display("FAIL div_read_start: ce_w=%b ce_r=%b addr=%0d want 0 1 16", B_CE_W, B_CE_R,
               BRAM_ADDR_R);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || B_CE_R !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL div_abort_read: busy=%b ce_r=%b valid=%b done=%b want 0 0 0 0", busy,
               B_CE_R, out_valid, done);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL div_abort_after: valid=%b done=%b want 0 0", out_valid, done);
    end
  endtask

  task automatic test_wrap_trigger();
    int got, cyc;
    logic [7:0] exp_b;
    arm_cfg(24'd0, 8'h01, 8'h01, 16'd8192, 16'd4);
    for (int n = 0; n <= 8192; n++) begin
      CAP = f3(n);
      #1;
      checks++;
      if (B_CE_W !== 1'b1 || BRAM_ADDR_W !== 13'(n) || BRAM_IN !== f3(n)) begin
        errors++;
        $display("FAIL wrap_write n=%0d: ce=%b addr=%0d data=%h", n, B_CE_W, BRAM_ADDR_W,
                 BRAM_IN);
      end
      checks++;
      if (triggered !== 1'(n >= 8189)) begin
        errors++;
        $display("FAIL wrap_trig n=%0d: trig=%b want %b", n, triggered, 1'(n >= 8189));
      end
      tick();
    end
    out_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 8192 && cyc < 17000) begin
      #1;
      if (cyc == 0) begin
        checks++;
        if (B_CE_R !== 1'b1 || BRAM_ADDR_R !== 13'd0) begin
          errors++;
          $display("FAIL wrap_stop: ce_r=%b addr=%0d want 1 0", B_CE_R, BRAM_ADDR_R);
        end
      end
      if (out_valid && out_ready) begin
        exp_b = f3((got == 0) ? 8192 : 8192 - got);
        checks++;
        if (out_data !== exp_b) begin
          errors++;
          $display("FAIL wrap_byte %0d: got %h want %h", got, out_data, exp_b);
        end
        got++;
      end
      if (got < 8192) begin
        tick();
        cyc++;
      end
    end
    checks++;
    if (got != 8192) begin
      errors++;
      $display("FAIL wrap_count: bytes=%0d want 8192", got);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done: done=%b want 1", done);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int got, cyc;
    arm_cfg(24'd0, 8'h80, 8'h80, 16'd32, 16'd0);
    for (int n = 0; n <= 128; n++) begin
      CAP = 8'(n);
      #1;
      checks++;
      if (B_CE_W !== 1'b1 || triggered !== 1'b0) begin
        errors++;
        $display("FAIL bp_capture n=%0d: ce=%b trig=%b want 1 0", n, B_CE_W, triggered);
      end
      tick();
    end
    checks++;
    if (triggered !== 1'b1 || BRAM_ADDR_R !== 13'd128) begin
      errors++;
      $display("FAIL bp_trigger: trig=%b rd_addr=%0d want 1 128", triggered, BRAM_ADDR_R);
    end
    out_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 10 && cyc < 200) begin
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== 8'(128 - got)) begin
          errors++;
          $display("FAIL bp_byte %0d: got %h want %h", got, out_data, 8'(128 - got));
        end
        got++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    for (int s = 0; s < 10; s++) begin
      #1;
      checks++;
      if (B_CE_R !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall_read s=%0d: ce_r=%b want 0", s, B_CE_R);
      end
      if (s >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'(118)) begin
          errors++;
          $display("FAIL bp_hold s=%0d: valid=%b data=%h want 1 76", s, out_valid, out_data);
        end
      end
      tick();
    end
    out_ready = 1'b1;
    while (got < 32 && cyc < 400) begin
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== 8'(128 - got)) begin
          errors++;
          $display("FAIL bp_byte %0d: got %h want %h", got, out_data, 8'(128 - got));
        end
        got++;
      end
      if (got < 32) begin
        tick();
        cyc++;
      end
    end
    checks++;
    if (got != 32) begin
      errors++;
      $display("FAIL bp_count: bytes=%0d want 32", got);
    end
    tick();
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: done=%b valid=%b want 1 0", done, out_valid);
    end
    tick();
  endtask

  task automatic test_abort();
    int got, cyc;
    arm_cfg(24'd0, 8'h00, 8'h00, 16'd16, 16'd8);
    for (int n = 0; n < 10; n++) begin
      CAP = 8'(n);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || B_CE_W !== 1'b0 || B_CE_R !== 1'b0 || out_valid !== 1'b0 ||
        done !== 1'b0) begin
      errors++;
      $display("FAIL abort_post: busy=%b ce_w=%b ce_r=%b valid=%b done=%b want all 0", busy,
               B_CE_W, B_CE_R, out_valid, done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet %0d: done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || B_CE_W !== 1'b0) begin
      errors++;
      $display("FAIL arm_with_abort: busy=%b ce_w=%b want 0 0", busy, B_CE_W);
    end
    tick();
    arm_cfg(24'd0, 8'h00, 8'h00, 16'd16, 16'd8);
    for (int n = 0; n <= 16; n++) begin
      CAP = 8'(8'h40 + n);
      tick();
    end
    out_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 16 && cyc < 100) begin
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== 8'(8'h40 + 16 - got)) begin
          errors++;
          $display("FAIL rearm_byte %0d: got %h want %h", got, out_data, 8'(8'h40 + 16 - got));
        end
        got++;
      end
      if (got < 16) begin
        tick();
        cyc++;
      end
    end
    tick();
    checks++;
    if (got != 16 || done !== 1'b1) begin
      errors++;
      $display("FAIL rearm_done: bytes=%0d done=%b want 16 1", got, done);
    end
    tick();
  endtask

  task automatic test_reset_in_read();
    int got, cyc;
    logic [47:0] all_o;
    arm_cfg(24'd0, 8'h00, 8'h00, 16'hFFFF, 16'hFFFF);
    for (int n = 0; n <= 8192; n++) begin
      CAP = 8'(n);
      #1;
      checks++;
      if (B_CE_W !== 1'b1 || BRAM_ADDR_W !== 13'(n) || triggered !== 1'(n >= 1)) begin
        errors++;
        $display("FAIL clamp_write n=%0d: ce=%b addr=%0d trig=%b", n, B_CE_W, BRAM_ADDR_W,
                 triggered);
      end
      tick();
    end
    #1;
    checks++;
    if (B_CE_W !== 1'b0 || B_CE_R !== 1'b1 || BRAM_ADDR_R !== 13'd0) begin
      errors++;
      $display("FAIL clamp_read_start: ce_w=%b ce_r=%b addr=%0d want 0 1 0", B_CE_W, B_CE_R,
               BRAM_ADDR_R);
    end
    out_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 20 && cyc < 100) begin
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== 8'(8192 - got)) begin
          errors++;
          $display("FAIL clamp_byte %0d: got %h want %h", got, out_data, 8'(8192 - got));
        end
        got++;
      end
      tick();
      #1;
      cyc++;
    end
    RST = 1'b1;
    tick();
    all_o = {BRAM_IN, BRAM_ADDR_W, B_CE_W, BRAM_ADDR_R, B_CE_R, out_data, out_valid, busy,
             triggered, done};
    checks++;
    if (got != 20 || all_o !== 48'd0) begin
      errors++;
      $display("FAIL rst_in_read: bytes=%0d outputs=%h want 20 0", got, all_o);
    end
    RST = 1'b0;
    out_ready = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: busy=%b done=%b valid=%b want 0 0 0", busy, done, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divider();
    test_wrap_trigger();
    test_backpressure();
    test_abort();
    test_reset_in_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Sequences one SUMP capture over the 8 KiB capture BRAM: sample-rate division, ring-buffer writes, pre-fill, trigger qualification, post-trigger count, then newest-first readback as a byte stream toward the UART TX path. It sits between the command decoder (configuration plus arm/abort) and the BRAM/UART TX datapath. It replaces the inline capture/TX states in main. It owns both BRAM address ports and both BRAM enables.

Parameters:
ADDR_W, 13, BRAM address width; depth = 2^ADDR_W = 8192 samples
DIV_W, 24, sample divider width
CNT_W, 16, read/delay count width, in samples

Ports:
CAP_CLK  in  1  capture/system clock, 48 MHz
RST  in  1  synchronous active-high reset
CAP  in  8  input channels
cfg_div  in  DIV_W  one sample every cfg_div+1 clocks
cfg_mask  in  8  trigger mask; 1 = channel participates
cfg_value  in  8  required level per masked channel
cfg_read_cnt  in  CNT_W  samples to return
cfg_delay_cnt  in  CNT_W  samples to capture after trigger
arm  in  1  start-capture pulse
abort  in  1  cancel-capture pulse
BRAM_IN  out  8  write data (= CAP on a write)
BRAM_ADDR_W  out  ADDR_W  write address
B_CE_W  out  1  write enable
BRAM_ADDR_R  out  ADDR_W  read address
B_CE_R  out  1  read enable
BRAM_OUT  in  8  read data, valid 1 cycle after B_CE_R
out_data  out  8  readback byte
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts byte
busy  out  1  high in every state except IDLE
triggered  out  1  trigger accepted in the current capture
done  out  1  one-cycle pulse at end of readback

Behaviour:
- Reset: state IDLE; all outputs 0; wr_addr, rd_addr, divider and counters are 0.
- arm in IDLE: latch all cfg_* values. Clamp read = min(cfg_read_cnt, 8192) and delay = min(cfg_delay_cnt, read). pre = read - delay. Clear triggered and counters, wr_addr = 0. Next state is PRE.
- arm while busy: ignored. abort in any state returns to IDLE next cycle, deasserts all enables and out_valid, and leaves BRAM contents unchanged. If arm and abort are high together, abort wins.
- Sample tick: the divider counts 0..div_latched and wraps. A tick occurs when the count is 0, including the first cycle after arm. If div = 0, every cycle is a tick.
- Capture states (PRE, WAIT_TRIG, POST): on each tick, B_CE_W = 1, BRAM_IN = CAP, BRAM_ADDR_W = wr_addr, then wr_addr increments modulo 2^ADDR_W (8191 wraps to 0). B_CE_W = 0 on non-tick cycles.
- PRE: count samples written, saturating at 8192. When the count reaches pre, go to WAIT_TRIG. If pre = 0, go to WAIT_TRIG immediately.
- WAIT_TRIG: the trigger is accepted on a tick where ((CAP ^ cfg_value) & cfg_mask) == 0. If mask = 0, the first WAIT_TRIG tick triggers. The trigger sample is written; set triggered = 1 and post_cnt = delay. If delay = 0, go to READ; otherwise go to POST. Non-tick cycles never trigger.
- POST: each tick decrements post_cnt. When the write makes it 0, record stop = the address just written and go to READ.
- With delay = 0, stop = the trigger sample's address.
- READ: emit read bytes newest first: addresses stop, stop-1, ... modulo 2^ADDR_W. B_CE_W = 0 and the divider is idle.
  - Issue a read with B_CE_R = 1; BRAM_OUT is registered into out_data on the next cycle and out_valid is set.
  - out_valid/out_data hold stable until out_ready. A byte transfers when out_valid && out_ready.
  - The next read may be issued in the cycle of the transfer, for one byte per 2 cycles with out_ready tied high.
  - After read transfers, go to DONE. If read = 0, go straight to DONE with no bytes.
- DONE: done = 1 for one cycle, then IDLE. triggered holds until the next arm or RST.
- Counts must be at least CNT_W+1 bits wide so 8192 is representable. No arithmetic wraps except the addresses.

Test Plan:
- div=0, mask=0, read=16, delay=8, CAP incrementing each cycle from 0x00 -> 8 PRE writes to addr 0-7; trigger sample 0x08 at addr 8; POST writes addr 9-16; stop=16; out bytes 0x10 down to 0x01 newest first; done after 16th transfer.
- div=3 -> B_CE_W high exactly one cycle in four, first on the cycle after arm; 16 samples take 64 cycles.
- mask=0x01, value=0x01, CH0 low for 100 ticks then high; read=8192, delay=4 -> trigger at addr 8188 ignored until pre-fill reached; stop wraps correctly; 8192 bytes returned, newest = addr (trigger+4) mod 8192.
- out_ready held low 10 cycles mid-readback -> out_data and out_valid stable, B_CE_R stays 0, no byte lost or duplicated.
- abort during POST -> IDLE next cycle, busy=0, no done pulse; a subsequent arm captures normally. Arm with abort high in the same cycle -> remains IDLE.
- RST asserted during READ -> next cycle all outputs 0 and state IDLE; cfg_read_cnt=0xFFFF clamps to 8192 bytes.
